// File: rtl/crc_engine.sv
// crc_engine: bit-serial CRC generator / checker with a beat-level valid/ready
// input and a held result output.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. The source holds valid and its data stable until that edge.
// s_ready is high only in IDLE. m_valid is high only in DONE. The result
// fields stay frozen until m_ready is seen.
//
// Optional feature: define CRC_ERRCNT_EN to add the 16-bit saturating err_cnt
// output. It counts check-mode results that report a CRC error.
module crc_engine #(
  parameter int             CRC_W  = 3,
  parameter logic [CRC_W-1:0] POLY = 3'b011,
  parameter int             DATA_W = 4,
  parameter logic [CRC_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_first,
  input  logic              s_last,
  input  logic              mode,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_error
`ifdef CRC_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CRC_W-1:0]  rem;
  logic [CRC_W-1:0]  rem_next;
  logic [DATA_W-1:0] data_sh;
  logic [CRC_W-1:0]  chk_sh;
  logic [CNT_W-1:0]  cnt;
  logic              last_q;
  logic              mode_q;
  logic              frame_open;
  logic              bit_in;

  assign s_ready = (state == IDLE);
  assign m_valid = (state == DONE);

  // One LFSR step: data bits in SHIFT, zeros or received CRC bits in FLUSH.
  always_comb begin
    bit_in   = (state == FLUSH) ? chk_sh[CRC_W-1] : data_sh[DATA_W-1];
    rem_next = {rem[CRC_W-2:0], bit_in} ^ (rem[CRC_W-1] ? POLY : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Non-last beats go back to IDLE with the frame still open.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_valid) state_next = SHIFT;
      SHIFT:   if (cnt == SHIFT_LAST) state_next = last_q ? FLUSH : IDLE;
      FLUSH:   if (cnt == FLUSH_LAST) state_next = DONE;
      DONE:    if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: beat capture, serial remainder update and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= INIT;
      data_sh    <= '0;
      chk_sh     <= '0;
      cnt        <= '0;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      frame_open <= 1'b0;
      crc_out    <= '0;
      crc_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            data_sh    <= s_data;
            last_q     <= s_last;
            mode_q     <= mode;
            chk_sh     <= mode ? crc_in : '0;
            cnt        <= '0;
            frame_open <= 1'b1;
            // A new first beat drops any partial frame; a stray beat opens one.
            if (s_first || !frame_open) rem <= INIT;
          end
        end
        SHIFT: begin
          rem     <= rem_next;
          data_sh <= data_sh << 1;
          cnt     <= (cnt == SHIFT_LAST) ? '0 : cnt + 1'b1;
        end
        FLUSH: begin
          rem    <= rem_next;
          chk_sh <= chk_sh << 1;
          cnt    <= (cnt == FLUSH_LAST) ? '0 : cnt + 1'b1;
          if (cnt == FLUSH_LAST) begin
            crc_out   <= mode_q ? '0 : rem_next;
            crc_error <= mode_q && (rem_next != '0);
          end
        end
        DONE: begin
          if (m_ready) frame_open <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CRC_ERRCNT_EN
  // Saturating count of failed check results, counted at the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((state == DONE) && m_ready && mode_q && crc_error &&
                 (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed table-driven bench for crc_engine at default
// parameters (x^3+x+1, 4-bit beats, INIT 0), plus multi-beat, stall, reset
// and (with CRC_ERRCNT_EN) error-counter sequences.
module tb_crc_engine;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       s_first;
  logic       s_last;
  logic       mode;
  logic [2:0] crc_in;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] crc_out;
  logic       crc_error;
`ifdef CRC_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  crc_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_first   (s_first),
    .s_last    (s_last),
    .mode      (mode),
    .crc_in    (crc_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .crc_out   (crc_out),
    .crc_error (crc_error)
`ifdef CRC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       mode;
    logic [2:0] crc_in;
    logic [2:0] exp_crc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present one beat, wait (bounded) for s_ready, transfer on the next edge.
  task automatic send_beat(input logic [3:0] d, input logic f, input logic l,
                           input logic md, input logic [2:0] ci);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready_timeout", int'(s_ready), 1);
    s_data  = d;
    s_first = f;
    s_last  = l;
    mode    = md;
    crc_in  = ci;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = $urandom_range(0, 15);
    s_first = 1'(($urandom_range(0, 1)));
    s_last  = 1'(($urandom_range(0, 1)));
    mode    = 1'(($urandom_range(0, 1)));
    crc_in  = $urandom_range(0, 7);
  endtask

  // Count edges from the accepting edge until m_valid (bounded).
  task automatic wait_result(output int edges);
    edges = 0;
    while (!m_valid && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    if (!m_valid) begin
      failures++;
      checks++;
      $display("FAIL result_timeout: got m_valid=0 expected 1 after %0d edges", edges);
    end
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [2:0] held_crc;
    s_valid = 0; s_data = 0; s_first = 0; s_last = 0;
    mode = 0; crc_in = 0; m_ready = 0; rst_n = 1'b0;

    vecs.push_back('{4'b1101, 1'b0, 3'b000, 3'b001, 1'b0});
    vecs.push_back('{4'b1101, 1'b1, 3'b001, 3'b000, 1'b0});
    vecs.push_back('{4'b1101, 1'b1, 3'b011, 3'b000, 1'b1});
    vecs.push_back('{4'b1000, 1'b0, 3'b000, 3'b101, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 3'b000, 3'b000, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 3'b000, 3'b111, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 3'b000, 3'b011, 1'b0});
    vecs.push_back('{4'b1000, 1'b1, 3'b101, 3'b000, 1'b0});
    vecs.push_back('{4'b1000, 1'b1, 3'b100, 3'b000, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 3'b111, 3'b000, 1'b0});

    // Reset state.
    #3;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_crc_out", int'(crc_out), 0);
    check("rst_crc_error", int'(crc_error), 0);
`ifdef CRC_ERRCNT_EN
    check("rst_err_cnt", int'(err_cnt), 0);
`endif
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat frames.
    foreach (vecs[i]) begin
      send_beat(vecs[i].data, 1'b1, 1'b1, vecs[i].mode, vecs[i].crc_in);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), lat, 7);
      check($sformatf("vec%0d_crc_out", i), int'(crc_out), int'(vecs[i].exp_crc));
      check($sformatf("vec%0d_crc_error", i), int'(crc_error), int'(vecs[i].exp_err));
      take_result();
      check($sformatf("vec%0d_idle", i), int'(s_ready), 1);
    end

    // Two-beat frame; the non-last beat returns to IDLE after 4 edges.
    send_beat(4'b1101, 1'b1, 1'b0, 1'b0, 3'b000);
    lat = 0;
    while (!s_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("nonlast_return_edges", lat, 4);
    check("nonlast_no_result", int'(m_valid), 0);
    send_beat(4'b0000, 1'b0, 1'b1, 1'b0, 3'b000);
    wait_result(lat);
    check("two_beat_crc", int'(crc_out), 3'b110);
    take_result();

    // Restart on s_first mid-frame discards the open partial frame.
    send_beat(4'b1111, 1'b1, 1'b0, 1'b0, 3'b000);
    send_beat(4'b1101, 1'b1, 1'b1, 1'b0, 3'b000);
    wait_result(lat);
    check("restart_crc", int'(crc_out), 3'b001);
    take_result();

    // A beat without s_first while no frame is open still starts from INIT.
    send_beat(4'b1101, 1'b0, 1'b1, 1'b0, 3'b000);
    wait_result(lat);
    check("implicit_open_crc", int'(crc_out), 3'b001);

    // Stall in DONE with s_valid pushing: output holds, nothing accepted.
    held_crc = 3'b001;
    s_valid = 1'b1;
    s_data  = 4'b1111;
    s_first = 1'b1;
    s_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_m_valid", k), int'(m_valid), 1);
      check($sformatf("stall%0d_crc_out", k), int'(crc_out), int'(held_crc));
      check($sformatf("stall%0d_s_ready", k), int'(s_ready), 0);
    end
    s_valid = 1'b0;
    take_result();
    check("stall_release_idle", int'(s_ready), 1);
    check("stall_release_m_valid", int'(m_valid), 0);

    // Reset pulsed mid-SHIFT aborts the frame immediately.
    send_beat(4'b1111, 1'b1, 1'b1, 1'b0, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", int'(s_ready), 1);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_crc_out", int'(crc_out), 0);
    check("midrst_crc_error", int'(crc_error), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_s_ready", int'(s_ready), 1);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_valid) lat++;
    end
    check("postrst_no_result", lat, 0);
    send_beat(4'b1101, 1'b1, 1'b1, 1'b0, 3'b000);
    wait_result(lat);
    check("postrst_latency", lat, 7);
    check("postrst_crc", int'(crc_out), 3'b001);
    take_result();

`ifdef CRC_ERRCNT_EN
    // Three failing checks and one passing check.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_beat(4'b1101, 1'b1, 1'b1, 1'b1, (k == 2) ? 3'b001 : 3'b011);
      wait_result(lat);
      check($sformatf("errcnt_frame%0d_err", k), int'(crc_error), (k == 2) ? 0 : 1);
      take_result();
    end
    check("err_cnt_final", int'(err_cnt), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
